// File: rtl/seq_mon_pkg.sv
// +----------------------------------------------------------------------------+
// | seq_mon_pkg : shared state encoding and default widths for the hit monitor  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package seq_mon_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } mon_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_win_timer.sv
// +----------------------------------------------------------------------------+
// | seq_win_timer : window down-counter, shadows the clamped length, flags     |
// |                 the final cycle of each window                             |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_win_timer #(
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIN_W-1:0] len_i,
  input  logic             run_i,
  input  logic             clr_i,
  output logic             last_o
);

  localparam logic [WIN_W-1:0] ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  logic [WIN_W-1:0] timer_q;
  logic [WIN_W-1:0] len_s_q;
  logic [WIN_W-1:0] len_clamp;

  assign len_clamp = (len_i == '0) ? ONE : len_i;
  assign last_o    = (timer_q == '0);

  // Reloading at zero keeps the timer from ever wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      len_s_q <= '0;
    end else if (load_i) begin
      len_s_q <= len_clamp;
      timer_q <= len_clamp - ONE;
    end else if (clr_i) begin
      timer_q <= '0;
    end else if (run_i) begin
      timer_q <= (timer_q == '0) ? (len_s_q - ONE) : (timer_q - ONE);
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_hit_monitor.sv
// +----------------------------------------------------------------------------+
// | seq_hit_monitor : windowed hit counter with saturation and acked alarm     |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_hit_monitor
  import seq_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hit,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  input  logic             alarm_ack,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] last_cnt,
  output logic             last_sat,
  output logic             win_done,
  output logic             alarm
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mon_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_cnt_q, last_cnt_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic             sat_q, sat_d;
  logic             last_sat_q, last_sat_d;
  logic             win_done_q, win_done_d;

  logic             running;
  logic             counting;
  logic             win_end;
  logic             hit_lost;
  logic [CNT_W-1:0] final_cnt;
  logic             alarm_cond;

  assign running  = (state_q != IDLE);
  assign counting = running && en;

  seq_win_timer #(
    .WIN_W (WIN_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i ((state_q == IDLE) && en),
    .len_i  (win_len),
    .run_i  (counting),
    .clr_i  (running && !en),
    .last_o (win_end)
  );

  // A hit arriving on a full counter is dropped and marks the window saturated.
  assign hit_lost   = hit && (cnt_q == CNT_MAX);
  assign final_cnt  = (hit && !hit_lost) ? (cnt_q + CNT_ONE) : cnt_q;
  assign alarm_cond = counting && win_end && (thresh_q != '0) && (final_cnt >= thresh_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en)            state_d = IDLE;
        else if (alarm_cond) state_d = ALARM;
      end
      ALARM: begin
        if (!en)                           state_d = IDLE;
        else if (!alarm_cond && alarm_ack) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alarm = (state_q == ALARM);
  end

  always_comb begin
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    last_cnt_d = last_cnt_q;
    last_sat_d = last_sat_q;
    thresh_d   = thresh_q;
    win_done_d = 1'b0;
    if (!running) begin
      cnt_d = '0;
      sat_d = 1'b0;
      if (en) thresh_d = thresh;
    end else if (!en) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (win_end) begin
      last_cnt_d = final_cnt;
      last_sat_d = sat_q || hit_lost;
      cnt_d      = '0;
      sat_d      = 1'b0;
      win_done_d = 1'b1;
    end else begin
      cnt_d = final_cnt;
      sat_d = sat_q || hit_lost;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      last_cnt_q <= '0;
      last_sat_q <= 1'b0;
      thresh_q   <= '0;
      win_done_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      last_cnt_q <= last_cnt_d;
      last_sat_q <= last_sat_d;
      thresh_q   <= thresh_d;
      win_done_q <= win_done_d;
    end
  end

  assign cnt      = cnt_q;
  assign last_cnt = last_cnt_q;
  assign last_sat = last_sat_q;
  assign win_done = win_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_hit_monitor.sv
// +----------------------------------------------------------------------------+
// | tb_seq_hit_monitor : directed self-checking bench for seq_hit_monitor      |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_hit_monitor;
  import seq_mon_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        hit;
  logic [15:0] win_len;
  logic [7:0]  thresh;
  logic        alarm_ack;
  logic [7:0]  cnt;
  logic [7:0]  last_cnt;
  logic        last_sat;
  logic        win_done;
  logic        alarm;

  int total = 0;
  int bad   = 0;

  seq_hit_monitor #(.CNT_W(8), .WIN_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .hit       (hit),
    .win_len   (win_len),
    .thresh    (thresh),
    .alarm_ack (alarm_ack),
    .cnt       (cnt),
    .last_cnt  (last_cnt),
    .last_sat  (last_sat),
    .win_done  (win_done),
    .alarm     (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (cnt !== 8'd0)      begin bad++; $display("FAIL rst_cnt got=%0d exp=0", cnt); end
    total++; if (last_cnt !== 8'd0) begin bad++; $display("FAIL rst_last_cnt got=%0d exp=0", last_cnt); end
    total++; if (last_sat !== 1'b0) begin bad++; $display("FAIL rst_last_sat got=%b exp=0", last_sat); end
    total++; if (win_done !== 1'b0) begin bad++; $display("FAIL rst_win_done got=%b exp=0", win_done); end
    total++; if (alarm !== 1'b0)    begin bad++; $display("FAIL rst_alarm got=%b exp=0", alarm); end
    tick(); tick();
    rst = 1'b0;
    hit = 1'b1;
    tick();
    total++; if (cnt !== 8'd0) begin bad++; $display("FAIL idle_ignores_hit got=%0d exp=0", cnt); end
    hit = 1'b0;
  endtask

  task automatic test_basic_windows();
    bit [3:0] pat;
    int exp_cnt;
    pat = 4'b1101;
    win_len = 16'd4; thresh = 8'd0; en = 1'b1;
    tick();
    for (int w = 0; w < 3; w++) begin
      exp_cnt = 0;
      for (int k = 0; k < 4; k++) begin
        hit = pat[k];
        tick();
        exp_cnt += int'(pat[k]);
        if (k < 3) begin
          total++; if (cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL basic_cnt w=%0d k=%0d got=%0d exp=%0d", w, k, cnt, exp_cnt); end
          total++; if (win_done !== 1'b0)   begin bad++; $display("FAIL basic_no_done w=%0d k=%0d got=%b exp=0", w, k, win_done); end
        end else begin
          total++; if (win_done !== 1'b1)  begin bad++; $display("FAIL basic_done w=%0d got=%b exp=1", w, win_done); end
          total++; if (last_cnt !== 8'd3)  begin bad++; $display("FAIL basic_last_cnt w=%0d got=%0d exp=3", w, last_cnt); end
          total++; if (cnt !== 8'd0)       begin bad++; $display("FAIL basic_cnt_clr w=%0d got=%0d exp=0", w, cnt); end
          total++; if (alarm !== 1'b0)     begin bad++; $display("FAIL basic_alarm w=%0d got=%b exp=0", w, alarm); end
        end
      end
    end
    hit = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_alarm_ack();
    win_len = 16'd5; thresh = 8'd2; en = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      hit = (k == 1 || k == 4);
      tick();
      if (k == 3) begin
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL ack_early_alarm got=%b exp=0", alarm); end
      end
    end
    total++; if (last_cnt !== 8'd2) begin bad++; $display("FAIL ack_last_cnt got=%0d exp=2", last_cnt); end
    total++; if (win_done !== 1'b1) begin bad++; $display("FAIL ack_done got=%b exp=1", win_done); end
    total++; if (alarm !== 1'b1)    begin bad++; $display("FAIL ack_alarm_set got=%b exp=1", alarm); end
    hit = 1'b0; alarm_ack = 1'b1;
    tick();
    alarm_ack = 1'b0;
    total++; if (alarm !== 1'b0)        begin bad++; $display("FAIL ack_alarm_clr got=%b exp=0", alarm); end
    total++; if (dut.state_q !== RUN)   begin bad++; $display("FAIL ack_state got=%0d exp=%0d", dut.state_q, RUN); end
    total++; if (win_done !== 1'b0)     begin bad++; $display("FAIL ack_done_clr got=%b exp=0", win_done); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    win_len = 16'd300; thresh = 8'd0; en = 1'b1;
    tick();
    hit = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k == 254 || k == 298) begin
        total++; if (cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt k=%0d got=%0d exp=255", k, cnt); end
      end
    end
    total++; if (last_cnt !== 8'd255) begin bad++; $display("FAIL sat_last_cnt got=%0d exp=255", last_cnt); end
    total++; if (last_sat !== 1'b1)   begin bad++; $display("FAIL sat_last_sat got=%b exp=1", last_sat); end
    total++; if (win_done !== 1'b1)   begin bad++; $display("FAIL sat_done got=%b exp=1", win_done); end
    total++; if (alarm !== 1'b0)      begin bad++; $display("FAIL sat_alarm_disabled got=%b exp=0", alarm); end
    hit = 1'b0;
    for (int k = 0; k < 300; k++) tick();
    total++; if (last_cnt !== 8'd0) begin bad++; $display("FAIL sat2_last_cnt got=%0d exp=0", last_cnt); end
    total++; if (last_sat !== 1'b0) begin bad++; $display("FAIL sat2_last_sat got=%b exp=0", last_sat); end
    total++; if (win_done !== 1'b1) begin bad++; $display("FAIL sat2_done got=%b exp=1", win_done); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_ack_collision();
    win_len = 16'd2; thresh = 8'd1; en = 1'b1;
    tick();
    hit = 1'b1; tick();
    hit = 1'b0; tick();
    total++; if (alarm !== 1'b1)    begin bad++; $display("FAIL coll_alarm1 got=%b exp=1", alarm); end
    total++; if (last_cnt !== 8'd1) begin bad++; $display("FAIL coll_last1 got=%0d exp=1", last_cnt); end
    hit = 1'b0; tick();
    hit = 1'b1; alarm_ack = 1'b1; tick();
    total++; if (alarm !== 1'b1)        begin bad++; $display("FAIL coll_alarm_kept got=%b exp=1", alarm); end
    total++; if (dut.state_q !== ALARM) begin bad++; $display("FAIL coll_state got=%0d exp=%0d", dut.state_q, ALARM); end
    total++; if (win_done !== 1'b1)     begin bad++; $display("FAIL coll_done got=%b exp=1", win_done); end
    hit = 1'b0; alarm_ack = 1'b1; tick();
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL coll_ack_clr got=%b exp=0", alarm); end
    alarm_ack = 1'b0; en = 1'b0; tick();
    total++; if (win_done !== 1'b0) begin bad++; $display("FAIL coll_abort_done got=%b exp=0", win_done); end
    total++; if (last_cnt !== 8'd1) begin bad++; $display("FAIL coll_abort_last got=%0d exp=1", last_cnt); end
  endtask

  task automatic test_abort();
    bit [4:0] pat;
    pat = 5'b01011;
    win_len = 16'd8; thresh = 8'd0; en = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      hit = pat[k];
      tick();
    end
    total++; if (cnt !== 8'd3) begin bad++; $display("FAIL abort_pre_cnt got=%0d exp=3", cnt); end
    en = 1'b0; hit = 1'b1; tick();
    total++; if (cnt !== 8'd0)           begin bad++; $display("FAIL abort_cnt got=%0d exp=0", cnt); end
    total++; if (win_done !== 1'b0)      begin bad++; $display("FAIL abort_done got=%b exp=0", win_done); end
    total++; if (last_cnt !== 8'd1)      begin bad++; $display("FAIL abort_last got=%0d exp=1", last_cnt); end
    total++; if (dut.state_q !== IDLE)   begin bad++; $display("FAIL abort_state got=%0d exp=%0d", dut.state_q, IDLE); end
    tick();
    total++; if (cnt !== 8'd0) begin bad++; $display("FAIL abort_idle_cnt got=%0d exp=0", cnt); end
    en = 1'b1; win_len = 16'd2; hit = 1'b0; tick();
    win_len = 16'd8;
    hit = 1'b1; tick();
    total++; if (win_done !== 1'b0) begin bad++; $display("FAIL reen_mid got=%b exp=0", win_done); end
    hit = 1'b1; tick();
    total++; if (win_done !== 1'b1) begin bad++; $display("FAIL reen_done1 got=%b exp=1", win_done); end
    total++; if (last_cnt !== 8'd2) begin bad++; $display("FAIL reen_last1 got=%0d exp=2", last_cnt); end
    hit = 1'b0; tick();
    total++; if (win_done !== 1'b0) begin bad++; $display("FAIL reen_gap got=%b exp=0", win_done); end
    hit = 1'b1; tick();
    total++; if (win_done !== 1'b1) begin bad++; $display("FAIL reen_done2 got=%b exp=1", win_done); end
    total++; if (last_cnt !== 8'd1) begin bad++; $display("FAIL reen_last2 got=%0d exp=1", last_cnt); end
    en = 1'b0; hit = 1'b0; tick();
  endtask

  task automatic test_win_len_one();
    bit [3:0] pat;
    pat = 4'b1101;
    win_len = 16'd0; thresh = 8'd0; en = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      hit = pat[k];
      tick();
      total++; if (win_done !== 1'b1)               begin bad++; $display("FAIL len1_done k=%0d got=%b exp=1", k, win_done); end
      total++; if (last_cnt !== {7'd0, pat[k]})     begin bad++; $display("FAIL len1_last k=%0d got=%0d exp=%0d", k, last_cnt, pat[k]); end
      total++; if (cnt !== 8'd0)                    begin bad++; $display("FAIL len1_cnt k=%0d got=%0d exp=0", k, cnt); end
    end
    en = 1'b0; hit = 1'b0; tick();
  endtask

  task automatic test_async_reset();
    win_len = 16'd10; thresh = 8'd1; en = 1'b1;
    tick();
    hit = 1'b1; tick();
    hit = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    hit = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    total++; if (cnt !== 8'd6)   begin bad++; $display("FAIL arst_pre_cnt got=%0d exp=6", cnt); end
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL arst_pre_alarm got=%b exp=1", alarm); end
    #3;
    rst = 1'b1;
    #1;
    total++; if (cnt !== 8'd0)      begin bad++; $display("FAIL arst_cnt got=%0d exp=0", cnt); end
    total++; if (alarm !== 1'b0)    begin bad++; $display("FAIL arst_alarm got=%b exp=0", alarm); end
    total++; if (last_cnt !== 8'd0) begin bad++; $display("FAIL arst_last got=%0d exp=0", last_cnt); end
    total++; if (last_sat !== 1'b0) begin bad++; $display("FAIL arst_sat got=%b exp=0", last_sat); end
    total++; if (win_done !== 1'b0) begin bad++; $display("FAIL arst_done got=%b exp=0", win_done); end
    tick();
    rst = 1'b0; en = 1'b0;
    tick(); tick();
    total++; if (cnt !== 8'd0)   begin bad++; $display("FAIL arst_quiet_cnt got=%0d exp=0", cnt); end
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL arst_quiet_alarm got=%b exp=0", alarm); end
    en = 1'b1; tick();
    tick();
    total++; if (cnt !== 8'd1) begin bad++; $display("FAIL arst_restart_cnt got=%0d exp=1", cnt); end
    en = 1'b0; hit = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; hit = 1'b0;
    win_len = 16'd0; thresh = 8'd0; alarm_ack = 1'b0;
    test_reset();
    test_basic_windows();
    test_alarm_ack();
    test_saturation();
    test_ack_collision();
    test_abort();
    test_win_len_one();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
